funnel_seq: RTL

FUNNEL_SEQ -- requirements
Module: funnel_seq

---
 rtl/funnel_pkg.sv | 14 +
 rtl/funnel_chunk_mux.sv | 30 +++
 rtl/funnel_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/funnel_pkg.sv
// Shared constants and helpers for the funnel sequencer: chunk width default,
// mode register width and the lane-mode clamp.
package funnel_pkg;

  localparam int unsigned ChunkWDefault = 128;
  localparam int unsigned ModeW         = 8;

  // Requested log2(lanes) beyond what the instance supports saturates to the widest mode.
  function automatic logic [ModeW-1:0] clamp_mode(input logic [ModeW-1:0] mode,
                                                   input logic [ModeW-1:0] max_mode);
    return (mode > max_mode) ? max_mode : mode;
  endfunction

endpackage

// File: rtl/funnel_chunk_mux.sv
// Selects, for each initiator lane, the chunk of the held word that belongs to
// the current beat; lanes outside the active set drive zero.
module funnel_chunk_mux
  import funnel_pkg::*;
#(
  parameter int unsigned CHUNKS    = 8,
  parameter int unsigned LANES_MAX = 4,
  parameter int unsigned CHUNK_W   = ChunkWDefault
) (
  input  logic [CHUNKS*CHUNK_W-1:0]    hold_i,
  input  logic [ModeW-1:0]             mode_i,
  input  logic [$clog2(CHUNKS)-1:0]    beat_i,
  output logic [LANES_MAX*CHUNK_W-1:0] dat_o
);

  int unsigned idx;

  always_comb begin
    dat_o = '0;
    idx   = 0;
    for (int unsigned j = 0; j < LANES_MAX; j++) begin
      if (j < (32'd1 << mode_i)) begin
        // Beat b on lane j carries chunk b*L + j.
        idx = (32'(beat_i) << mode_i) + j;
        dat_o[j*CHUNK_W +: CHUNK_W] = hold_i[idx*CHUNK_W +: CHUNK_W];
      end
    end
  end

endmodule

// File: rtl/funnel_seq.sv
// Width funnel: accepts a CHUNKS-chunk word and streams it over 2^M initiator
// lanes in CHUNKS/2^M beats, with per-lane handshakes collected into a beat.
module funnel_seq
  import funnel_pkg::*;
#(
  parameter int unsigned CHUNKS    = 8,
  parameter int unsigned LANES_MAX = 4,
  parameter int unsigned CHUNK_W   = ChunkWDefault
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         t_0_req,
  output logic                         t_0_ack,
  input  logic [CHUNKS*CHUNK_W-1:0]    t_0_dat,
  input  logic                         t_cfg_req,
  output logic                         t_cfg_ack,
  input  logic [ModeW-1:0]             t_cfg_mode,
  output logic [LANES_MAX-1:0]         i_req,
  input  logic [LANES_MAX-1:0]         i_ack,
  output logic [LANES_MAX*CHUNK_W-1:0] i_dat,
  output logic                         i_last,
  output logic                         busy
);

  localparam int unsigned      BeatW   = $clog2(CHUNKS);
  localparam logic [ModeW-1:0] MaxMode = ModeW'($clog2(LANES_MAX));

  logic                      busy_q, busy_d;
  logic [BeatW-1:0]          beat_q, beat_d;
  logic [LANES_MAX-1:0]      done_q, done_d;
  logic [ModeW-1:0]          mode_q, mode_d;
  logic [CHUNKS*CHUNK_W-1:0] hold_q, hold_d;

  logic [LANES_MAX-1:0] active;
  logic [LANES_MAX-1:0] lane_fin;
  logic [BeatW-1:0]     last_idx;
  logic                 last_beat, beat_fin, word_fin, cfg_fire, word_fire;

  always_comb begin
    for (int unsigned j = 0; j < LANES_MAX; j++) begin
      active[j] = (j < (32'd1 << mode_q));
    end
    last_idx  = BeatW'((CHUNKS >> mode_q) - 1);
    last_beat = (beat_q == last_idx);
    // Inactive lanes never hold a beat back.
    lane_fin  = done_q | i_ack | ~active;
    beat_fin  = busy_q & (&lane_fin);
    word_fin  = beat_fin & last_beat;
    t_cfg_ack = ~reset & ~busy_q;
    cfg_fire  = t_cfg_req & t_cfg_ack;
    t_0_ack   = ~reset & ((~busy_q & ~cfg_fire) | word_fin);
    word_fire = t_0_req & t_0_ack;
    i_req     = {LANES_MAX{busy_q & ~reset}} & active & ~done_q;
    i_last    = busy_q & ~reset & last_beat;
  end

  always_comb begin
    busy_d = busy_q;
    beat_d = beat_q;
    done_d = done_q;
    mode_d = mode_q;
    hold_d = hold_q;
    if (cfg_fire) begin
      mode_d = clamp_mode(t_cfg_mode, MaxMode);
    end
    if (beat_fin) begin
      done_d = '0;
      beat_d = last_beat ? '0 : beat_q + 1'b1;
      if (last_beat) begin
        busy_d = 1'b0;
      end
    end else begin
      done_d = done_q | (i_req & i_ack);
    end
    // A word captured in the final-beat cycle overrides the drain above.
    if (word_fire) begin
      hold_d = t_0_dat;
      busy_d = 1'b1;
      beat_d = '0;
      done_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      beat_q <= '0;
      done_q <= '0;
      mode_q <= MaxMode;
      hold_q <= '0;
    end else begin
      busy_q <= busy_d;
      beat_q <= beat_d;
      done_q <= done_d;
      mode_q <= mode_d;
      hold_q <= hold_d;
    end
  end

  assign busy = busy_q;

  funnel_chunk_mux #(
    .CHUNKS   (CHUNKS),
    .LANES_MAX(LANES_MAX),
    .CHUNK_W  (CHUNK_W)
  ) u_chunk_mux (
    .hold_i(hold_q),
    .mode_i(mode_q),
    .beat_i(beat_q),
    .dat_o (i_dat)
  );

endmodule
